div_sequencer: RTL and testbench



---
 rtl/rv_pkg.sv | 19 +
 rtl/div_step.sv | 23 ++
 rtl/div_sequencer.sv | 133 +++++++++++++
 tb/tb_div_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32M divide definitions: XLEN, sequencer state encoding and m_con opcodes.
package rv_pkg;

   localparam int XLEN = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_PREP  = 3'd1,
      S_CALC  = 3'd2,
      S_FIXUP = 3'd3,
      S_DONE  = 3'd4
   } div_state_e;

   localparam logic [3:0] MCON_DIV  = 4'b1000;
   localparam logic [3:0] MCON_DIVU = 4'b1001;
   localparam logic [3:0] MCON_REM  = 4'b1010;
   localparam logic [3:0] MCON_REMU = 4'b1011;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration on unsigned magnitudes.
module div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem,
   input  logic [XLEN-1:0] quo,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] next_rem,
   output logic [XLEN-1:0] next_quo
);

   logic [XLEN:0] shifted;
   logic [XLEN:0] trial;

   // rem < divisor always holds, so the XLEN+1 bit trial cannot wrap and its MSB is the sign.
   always_comb begin
      shifted  = {rem, quo[XLEN-1]};
      trial    = shifted - {1'b0, divisor};
      next_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
      next_quo = {quo[XLEN-2:0], ~trial[XLEN]};
   end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer: stalls the pipeline while div_step runs XLEN times.
module div_sequencer
   import rv_pkg::*;
#(
   parameter int XLEN = rv_pkg::XLEN
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [3:0]      m_con,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            stall,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CNT_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   div_state_e state, next_state;

   logic [1:0]      op;
   logic [XLEN-1:0] dividend, divisor, rem, quo;
   logic [CNT_W-1:0] cnt;
   logic            q_neg, r_neg;

   logic            accept, is_signed, div_zero, overflow;
   logic [XLEN-1:0] abs_a, abs_b, step_rem, step_quo;

   assign accept    = start && m_con[3];
   assign is_signed = ~op[0];
   assign div_zero  = (divisor == '0);
   assign overflow  = is_signed && (dividend == MIN_NEG) && (divisor == '1);
   assign abs_a     = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
   assign abs_b     = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;

   div_step #(.XLEN(XLEN)) u_step (
      .rem      (rem),
      .quo      (quo),
      .divisor  (divisor),
      .next_rem (step_rem),
      .next_quo (step_quo)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      stall      = 1'b0;
      busy       = (state != S_IDLE);
      done       = 1'b0;
      case (state)
         S_IDLE: begin
            if (accept) begin
               next_state = S_PREP;
               stall      = 1'b1;
            end
         end
         S_PREP: begin
            stall      = 1'b1;
            next_state = (div_zero || overflow) ? S_DONE : S_CALC;
         end
         S_CALC: begin
            stall = 1'b1;
            if (cnt == '0) next_state = S_FIXUP;
         end
         S_FIXUP: begin
            stall      = 1'b1;
            next_state = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            next_state = S_IDLE;
         end
         default: next_state = S_IDLE;
      endcase
      if (flush && state != S_IDLE) next_state = S_IDLE;
   end

   // Operands are latched raw; PREP swaps the divisor for its magnitude before CALC.
   always_ff @(posedge clk) begin
      if (rst) begin
         op       <= '0;
         dividend <= '0;
         divisor  <= '0;
         rem      <= '0;
         quo      <= '0;
         cnt      <= '0;
         q_neg    <= 1'b0;
         r_neg    <= 1'b0;
         result   <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op       <= m_con[1:0];
                  dividend <= rs1;
                  divisor  <= rs2;
               end
            end
            S_PREP: begin
               rem     <= '0;
               quo     <= abs_a;
               divisor <= abs_b;
               cnt     <= CNT_W'(XLEN - 1);
               q_neg   <= is_signed && (dividend[XLEN-1] ^ divisor[XLEN-1]);
               r_neg   <= is_signed && dividend[XLEN-1];
               if (!flush) begin
                  if (div_zero)      result <= op[1] ? dividend : '1;
                  else if (overflow) result <= op[1] ? '0 : MIN_NEG;
               end
            end
            S_CALC: begin
               rem <= step_rem;
               quo <= step_quo;
               cnt <= cnt - 1'b1;
            end
            S_FIXUP: begin
               if (!flush)
                  result <= op[1] ? (r_neg ? -rem : rem) : (q_neg ? -quo : quo);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed plus randomized bench for div_sequencer against an arithmetic reference model.
module tb_div_sequencer;

   localparam logic [31:0] MIN_NEG = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [3:0]  m_con;
   logic [31:0] rs1, rs2;
   logic        flush;
   logic        stall, busy, done;
   logic [31:0] result;

   int checks   = 0;
   int failures = 0;
   logic [31:0] last_result;

   div_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .m_con  (m_con),
      .rs1    (rs1),
      .rs2    (rs2),
      .flush  (flush),
      .stall  (stall),
      .busy   (busy),
      .done   (done),
      .result (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // RV32M semantics straight from the ISA rules, using 64-bit arithmetic.
   function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : MIN_NEG;
      if (!op[0]) begin
         sa = longint'($signed(a));
         sb = longint'($signed(b));
      end else begin
         sa = longint'({32'd0, a});
         sb = longint'({32'd0, b});
      end
      q = sa / sb;
      r = sa % sb;
      return op[1] ? r[31:0] : q[31:0];
   endfunction

   function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 2;
      if (!op[0] && a == MIN_NEG && b == 32'hFFFF_FFFF) return 2;
      return 35;
   endfunction

   // Issue at cycle 0 and check stall/busy/done every cycle through the IDLE cycle after DONE.
   task automatic run_op(input logic [3:0] mc, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_v, input bit hold);
      int lat;
      lat = ref_lat(mc[1:0], a, b);
      @(negedge clk);
      start = 1'b1; m_con = mc; rs1 = a; rs2 = b;
      #1 chk("stall_c0", {31'd0, stall}, 32'd1);
      for (int c = 1; c <= lat + 1; c++) begin
         @(posedge clk);
         #1;
         if (!hold) start = 1'b0;
         chk($sformatf("stall_c%0d", c), {31'd0, stall}, {31'd0, c < lat});
         chk($sformatf("busy_c%0d", c),  {31'd0, busy},  {31'd0, c <= lat});
         chk($sformatf("done_c%0d", c),  {31'd0, done},  {31'd0, c == lat});
         if (c == lat) begin
            chk($sformatf("result_m%h_%h_%h", mc, a, b), result, exp_v);
            last_result = exp_v;
            start = 1'b0;
         end
      end
   endtask

   initial begin
      int done_seen;
      logic [1:0]  op;
      logic [31:0] a, b;
      int sel;

      rst = 1'b1; start = 1'b0; m_con = 4'd0; rs1 = '0; rs2 = '0; flush = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_stall",  {31'd0, stall}, 32'd0);
      chk("reset_busy",   {31'd0, busy},  32'd0);
      chk("reset_done",   {31'd0, done},  32'd0);
      chk("reset_result", result,         32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_result = 32'd0;

      run_op(4'b1000, 32'd100, 32'd7, 32'd14, 1'b0);
      run_op(4'b1010, 32'd100, 32'd7, 32'd2, 1'b0);
      run_op(4'b1010, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
      run_op(4'b1000, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
      run_op(4'b1001, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF, 1'b0);
      run_op(4'b1011, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b0);
      run_op(4'b1000, MIN_NEG, 32'hFFFF_FFFF, MIN_NEG, 1'b0);
      run_op(4'b1010, MIN_NEG, 32'hFFFF_FFFF, 32'd0, 1'b0);
      run_op(4'b1001, 32'd1000, 32'd10, 32'd100, 1'b1);

      // Flush at cycle 10 must abort silently and leave result alone.
      @(negedge clk);
      start = 1'b1; m_con = 4'b1000; rs1 = 32'd1000; rs2 = 32'd3;
      for (int c = 1; c <= 10; c++) begin
         @(posedge clk);
         #1 start = 1'b0;
      end
      flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      chk("flush_busy",   {31'd0, busy},  32'd0);
      chk("flush_stall",  {31'd0, stall}, 32'd0);
      chk("flush_done",   {31'd0, done},  32'd0);
      chk("flush_result", result,         last_result);
      done_seen = 0;
      repeat (30) begin
         @(posedge clk);
         #1 if (done) done_seen++;
      end
      chk("flush_no_done", done_seen, 32'd0);

      // Reset at cycle 20 of a later op.
      @(negedge clk);
      start = 1'b1; m_con = 4'b1011; rs1 = 32'd77; rs2 = 32'd5;
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1 start = 1'b0;
      end
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_busy",   {31'd0, busy},  32'd0);
      chk("midrst_stall",  {31'd0, stall}, 32'd0);
      chk("midrst_done",   {31'd0, done},  32'd0);
      chk("midrst_result", result,         32'd0);
      last_result = 32'd0;
      run_op(4'b1001, 32'd9, 32'd3, 32'd3, 1'b0);

      // Non-divide m_con is ignored.
      @(negedge clk);
      start = 1'b1; m_con = 4'b0000; rs1 = 32'd5; rs2 = 32'd1;
      #1 chk("ignore_stall", {31'd0, stall}, 32'd0);
      @(posedge clk);
      #1 chk("ignore_busy", {31'd0, busy}, 32'd0);
      start = 1'b0;

      for (int i = 0; i < 24; i++) begin
         op  = 2'($urandom_range(0, 3));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 9);
         case (sel)
            0: b = 32'd0;
            1: begin a = MIN_NEG; b = 32'hFFFF_FFFF; end
            2: b = 32'($urandom_range(1, 15));
            3: a = 32'($urandom_range(0, 100));
            4: b = -32'($urandom_range(1, 15));
            default: ;
         endcase
         run_op({2'b10, op}, a, b, ref_res(op, a, b), 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
